ttl_univ_shift: RTL and testbench
=================================

TTL_UNIV_SHIFT -- requirements
Module: ttl_univ_shift

Interface
REQ-001 Parameter WIDTH, default 8, bits per plane; legal range 2..32.
REQ-002 Parameter PLANES, default 4, number of bitplanes shifted in lockstep; legal range 1..8.
REQ-003 Derived constant CW = ceil(log2(WIDTH+1)), the width of the remain counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce  in  1  clock enable for the shift register and counter.
REQ-007 mode  in  2  {S1,S0}: 00 hold, 01 shift toward MSB, 10 shift toward LSB, 11 parallel load.
REQ-008 dsr  in  PLANES  serial inputs entering bit 0 on a shift toward MSB.
REQ-009 dsl  in  PLANES  serial inputs entering bit WIDTH-1 on a shift toward LSB.
REQ-010 pin  in  PLANES*WIDTH  parallel load data; plane p occupies [p*WIDTH +: WIDTH].
REQ-011 auto  in  1  enables automatic reload from the holding buffer.
REQ-012 buf_wr  in  1  holding-buffer write strike.
REQ-013 buf_data  in  PLANES*WIDTH  holding-buffer write data, same packing as pin.
REQ-014 buf_full  out  1  holding buffer holds unconsumed data.
REQ-015 q  out  PLANES*WIDTH  full register contents.
REQ-016 q_lsb  out  PLANES  bit 0 of each plane.
REQ-017 q_msb  out  PLANES  bit WIDTH-1 of each plane.
REQ-018 remain  out  CW  count of valid bits not yet shifted out.
REQ-019 underrun  out  1  one-cycle pulse; register emptied with no reload available.

Function
REQ-020 All outputs are registered; q_lsb and q_msb are direct slices of q.
REQ-021 When ce=0, q, remain and underrun-generation are frozen; the buffer write path ignores ce.
REQ-022 Mode 00 with ce=1: q and remain hold.
REQ-023 Mode 11 with ce=1: q<=pin and remain<=WIDTH; this has priority over auto-reload and does not consume the buffer.
REQ-024 Mode 01 with ce=1: each plane p becomes {plane[WIDTH-2:0], dsr[p]}.
REQ-025 Mode 10 with ce=1: each plane p becomes {dsl[p], plane[WIDTH-1:1]}.
REQ-026 On every shift, remain decrements by 1, saturating at 0.
REQ-027 Reload condition: shift mode, ce=1, auto=1, buf_full=1, and remain is 1 or 0.
  - q<=buffer contents in place of the shift.
  - remain<=WIDTH.
  - Buffer is consumed.
REQ-028 Shift with ce=1 and remain=1 that is not a reload: normal shift, remain<=0, underrun=1 on the next cycle for exactly one cycle.
  - The auto value is irrelevant here.
REQ-029 Shift with remain=0 and no reload: normal shift, remain stays 0, no further underrun pulse.
REQ-030 buf_wr with buf_full=0: buffer<=buf_data, buf_full<=1.
REQ-031 buf_wr with buf_full=1 and no same-cycle reload: the write is dropped and the buffer is unchanged.
REQ-032 buf_wr in the same cycle as a reload: the reload takes the old buffer contents, the buffer takes buf_data, and buf_full stays 1.
REQ-033 Reload without buf_wr: buf_full<=0.
REQ-034 With auto=0 the buffer is never consumed.

Reset
REQ-035 reset=1 sets q=0, remain=0, buffer=0, buf_full=0 and underrun=0 at the next edge, regardless of ce, mode or buf_wr.
REQ-036 Reset asserted mid-shift or mid-reload discards all pending data; the first post-reset cycle behaves as idle.

Verification (WIDTH=8, PLANES=2)
REQ-037 Load and shift toward MSB:
  - Stimulus: mode=11, pin=16'hA5_3C, ce=1; then mode=01 with dsr=2'b11 for 3 cycles.
  - Response: q=16'h2F_E7, remain=5.
REQ-038 Seamless reload:
  - Stimulus: buf_wr with buf_data=16'h0F_F0, auto=1; load 16'hFF_00; 8 shifts toward LSB.
  - Response: after the 8th shift q=16'h0F_F0, remain=8, buf_full=0, underrun never asserted.
REQ-039 Underrun:
  - Stimulus: auto=1, buffer empty, load, 8 shifts.
  - Response: remain=0 and underrun high exactly one cycle.
  - Follow-up: a 9th shift gives no pulse; buf_wr then a shift reloads with remain=8.
REQ-040 Buffer contention:
  - Stimulus: buf_full=1, buf_wr of 16'h1111 (dropped); then buf_wr of 16'h2222 coincident with a reload.
  - Response: q=old buffer, buffer=16'h2222, buf_full=1.
REQ-041 Enable and priority:
  - ce=0 with mode=01 for 4 cycles: q and remain unchanged.
  - mode=11 with remain=1, auto=1, buf_full=1: q=pin, buf_full stays 1.
REQ-042 Reset mid-operation:
  - Stimulus: reset asserted with remain=3, buf_full=1, buf_wr=1.
  - Response: all outputs 0 the next cycle.

Source files
------------

// File: rtl/ttl_univ_shift.sv
// Multi-plane universal shift register with a single-entry holding buffer
// that can auto-reload the register as its last valid bit goes out.
module ttl_univ_shift #(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned PLANES = 4,
    localparam int unsigned CW     = $clog2(WIDTH + 1),
    localparam int unsigned TW     = PLANES * WIDTH
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ce_i,
    input  logic [1:0]        mode_i,
    input  logic [PLANES-1:0] dsr_i,
    input  logic [PLANES-1:0] dsl_i,
    input  logic [TW-1:0]     pin_i,
    input  logic              auto_i,
    input  logic              buf_wr_i,
    input  logic [TW-1:0]     buf_data_i,
    output logic              buf_full_o,
    output logic [TW-1:0]     q_o,
    output logic [PLANES-1:0] q_lsb_o,
    output logic [PLANES-1:0] q_msb_o,
    output logic [CW-1:0]     remain_o,
    output logic              underrun_o
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHL   = 2'b01;
    localparam logic [1:0] MODE_SHR   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [TW-1:0] q_q, q_d;
    logic [TW-1:0] buf_q, buf_d;
    logic          full_q, full_d;
    logic [CW-1:0] remain_q, remain_d;
    logic          underrun_q, underrun_d;
    logic          shift_c;
    logic          reload_c;

    // Reload replaces the shift that would empty (or has emptied) the register.
    assign shift_c  = ce_i && ((mode_i == MODE_SHL) || (mode_i == MODE_SHR));
    assign reload_c = shift_c && auto_i && full_q && (remain_q <= CW'(1));

    always_comb begin
        q_d        = q_q;
        remain_d   = remain_q;
        underrun_d = 1'b0;
        buf_d      = buf_q;
        full_d     = full_q;

        if (ce_i) begin
            case (mode_i)
                MODE_LOAD: begin
                    q_d      = pin_i;
                    remain_d = CW'(WIDTH);
                end
                MODE_SHL, MODE_SHR: begin
                    if (reload_c) begin
                        q_d      = buf_q;
                        remain_d = CW'(WIDTH);
                    end else begin
                        for (int p = 0; p < int'(PLANES); p++) begin
                            if (mode_i == MODE_SHL) begin
                                q_d[p*WIDTH +: WIDTH] = {q_q[p*WIDTH +: WIDTH-1], dsr_i[p]};
                            end else begin
                                q_d[p*WIDTH +: WIDTH] = {dsl_i[p], q_q[p*WIDTH+1 +: WIDTH-1]};
                            end
                        end
                        if (remain_q != '0) begin
                            remain_d = remain_q - CW'(1);
                        end
                        underrun_d = (remain_q == CW'(1));
                    end
                end
                default: ;
            endcase
        end

        // Buffer write path is independent of ce.
        if (reload_c) begin
            if (buf_wr_i) begin
                buf_d = buf_data_i;
            end else begin
                full_d = 1'b0;
            end
        end else if (buf_wr_i && !full_q) begin
            buf_d  = buf_data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q        <= '0;
            buf_q      <= '0;
            full_q     <= 1'b0;
            remain_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            remain_q   <= remain_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        q_lsb_o = '0;
        q_msb_o = '0;
        for (int p = 0; p < int'(PLANES); p++) begin
            q_lsb_o[p] = q_q[p*WIDTH];
            q_msb_o[p] = q_q[p*WIDTH + WIDTH - 1];
        end
    end

    assign q_o        = q_q;
    assign remain_o   = remain_q;
    assign underrun_o = underrun_q;
    assign buf_full_o = full_q;

endmodule

// File: tb/tb_ttl_univ_shift.sv
// Directed bench for ttl_univ_shift at WIDTH=8, PLANES=2.
module tb_ttl_univ_shift;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned PLANES = 2;
    localparam int unsigned CW     = $clog2(WIDTH + 1);
    localparam int unsigned TW     = WIDTH * PLANES;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce;
    logic [1:0]        mode;
    logic [PLANES-1:0] dsr;
    logic [PLANES-1:0] dsl;
    logic [TW-1:0]     pin;
    logic              auto_rl;
    logic              buf_wr;
    logic [TW-1:0]     buf_data;
    logic              buf_full;
    logic [TW-1:0]     q;
    logic [PLANES-1:0] q_lsb;
    logic [PLANES-1:0] q_msb;
    logic [CW-1:0]     remain;
    logic              underrun;

    int n_checks = 0;
    int n_pass   = 0;
    int ur_cnt;

    always #5 clk = ~clk;

    ttl_univ_shift #(.WIDTH(WIDTH), .PLANES(PLANES)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .ce_i       (ce),
        .mode_i     (mode),
        .dsr_i      (dsr),
        .dsl_i      (dsl),
        .pin_i      (pin),
        .auto_i     (auto_rl),
        .buf_wr_i   (buf_wr),
        .buf_data_i (buf_data),
        .buf_full_o (buf_full),
        .q_o        (q),
        .q_lsb_o    (q_lsb),
        .q_msb_o    (q_msb),
        .remain_o   (remain),
        .underrun_o (underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges, counting underrun pulses seen after each.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (underrun === 1'b1) ur_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; mode = 2'b00; dsr = '0; dsl = '0;
        pin = '0; auto_rl = 1'b0; buf_wr = 1'b0; buf_data = '0;
        tick();
        reset = 1'b0;
        check("rst_q",        32'(q),        32'h0);
        check("rst_remain",   32'(remain),   32'd0);
        check("rst_full",     32'(buf_full), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Load then shift toward MSB
        mode = 2'b11; pin = 16'hA53C;
        tick();
        check("load_q",      32'(q),      32'hA53C);
        check("load_remain", 32'(remain), 32'd8);
        mode = 2'b01; dsr = 2'b11;
        run(3);
        mode = 2'b00;
        check("shl_q",      32'(q),      32'h2FE7);
        check("shl_remain", 32'(remain), 32'd5);
        check("shl_lsb",    32'(q_lsb),  32'h3);
        check("shl_msb",    32'(q_msb),  32'h1);
        tick();
        check("hold_q",      32'(q),      32'h2FE7);
        check("hold_remain", 32'(remain), 32'd5);

        // Seamless reload on the 8th shift toward LSB
        buf_wr = 1'b1; buf_data = 16'h0FF0;
        tick();
        buf_wr = 1'b0;
        check("sr_full", 32'(buf_full), 32'd1);
        auto_rl = 1'b1; mode = 2'b11; pin = 16'hFF00;
        tick();
        mode = 2'b10; dsl = 2'b00; ur_cnt = 0;
        run(7);
        check("sr_q7",      32'(q),      32'h0100);
        check("sr_remain7", 32'(remain), 32'd1);
        run(1);
        mode = 2'b00;
        run(1);
        check("sr_q",      32'(q),        32'h0FF0);
        check("sr_remain", 32'(remain),   32'd8);
        check("sr_full0",  32'(buf_full), 32'd0);
        check("sr_ur_cnt", 32'(ur_cnt),   32'd0);

        // Underrun with an empty buffer
        mode = 2'b11; pin = 16'h1234;
        tick();
        mode = 2'b01; dsr = 2'b00; ur_cnt = 0;
        run(7);
        check("ur_pre", 32'(underrun), 32'd0);
        run(1);
        check("ur_pulse",  32'(underrun), 32'd1);
        check("ur_remain", 32'(remain),   32'd0);
        check("ur_q",      32'(q),        32'h0000);
        run(1);
        check("ur_9th_remain", 32'(remain), 32'd0);
        mode = 2'b00;
        run(2);
        check("ur_cnt", 32'(ur_cnt), 32'd1);
        buf_wr = 1'b1; buf_data = 16'h5AA5;
        tick();
        buf_wr = 1'b0;
        check("ur_full", 32'(buf_full), 32'd1);
        mode = 2'b01;
        tick();
        mode = 2'b00;
        check("ur_rl_q",      32'(q),        32'h5AA5);
        check("ur_rl_remain", 32'(remain),   32'd8);
        check("ur_rl_full",   32'(buf_full), 32'd0);

        // Buffer contention: dropped write, then write coincident with reload
        buf_wr = 1'b1; buf_data = 16'h3C3C;
        tick();
        buf_data = 16'h1111;
        tick();
        buf_wr = 1'b0;
        mode = 2'b10;
        run(7);
        check("bc_remain1", 32'(remain), 32'd1);
        buf_wr = 1'b1; buf_data = 16'h2222;
        tick();
        buf_wr = 1'b0; mode = 2'b00;
        check("bc_q",      32'(q),        32'h3C3C);
        check("bc_remain", 32'(remain),   32'd8);
        check("bc_full",   32'(buf_full), 32'd1);
        mode = 2'b10;
        run(8);
        mode = 2'b00;
        check("bc_q2",    32'(q),        32'h2222);
        check("bc_full2", 32'(buf_full), 32'd0);

        // Clock enable freeze; buffer write still accepted
        ce = 1'b0; mode = 2'b01; dsr = 2'b11;
        buf_wr = 1'b1; buf_data = 16'h7777;
        tick();
        buf_wr = 1'b0;
        run(3);
        check("ce_q",      32'(q),        32'h2222);
        check("ce_remain", 32'(remain),   32'd8);
        check("ce_full",   32'(buf_full), 32'd1);

        // Load takes priority over a pending reload
        ce = 1'b1; auto_rl = 1'b0; mode = 2'b01;
        run(7);
        check("pr_remain1", 32'(remain),   32'd1);
        check("pr_full_a0", 32'(buf_full), 32'd1);
        auto_rl = 1'b1; mode = 2'b11; pin = 16'hBEEF;
        tick();
        mode = 2'b00;
        check("pr_q",      32'(q),        32'hBEEF);
        check("pr_remain", 32'(remain),   32'd8);
        check("pr_full",   32'(buf_full), 32'd1);

        // Reset mid-operation
        mode = 2'b10;
        run(5);
        check("rm_remain3", 32'(remain), 32'd3);
        reset = 1'b1; buf_wr = 1'b1; buf_data = 16'h9999; mode = 2'b01;
        tick();
        reset = 1'b0; buf_wr = 1'b0; mode = 2'b00;
        check("rm_q",        32'(q),        32'h0);
        check("rm_remain",   32'(remain),   32'd0);
        check("rm_full",     32'(buf_full), 32'd0);
        check("rm_underrun", 32'(underrun), 32'd0);
        check("rm_lsbmsb",   32'({q_lsb, q_msb}), 32'h0);
        tick();
        check("rm_idle_q",  32'(q),        32'h0);
        check("rm_idle_ur", 32'(underrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
